// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with CTRL/PRESET/COUNT words.
// Ports: clk, reset (sync, active-high); Addr/WE/Din from the memory stage;
//   Dout = combinational read data; IRQ = registered IM & irq_flag.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] W_CTRL   = 2'd0;
  localparam logic [1:0] W_PRESET = 2'd1;
  localparam logic [1:0] W_COUNT  = 2'd2;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic [1:0]  state_q, state_d;

  logic        hit;
  logic [1:0]  wsel;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic        im;
  logic        periodic;
  logic        unused_addr;

  assign hit  = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wsel = Addr[3:2];

  // Byte lane bits carry no meaning for word registers.
  assign unused_addr = ^Addr[1:0];

  assign ctrl_wr   = WE & hit & (wsel == W_CTRL);
  assign preset_wr = WE & hit & (wsel == W_PRESET);

  assign en       = ctrl_q[0];
  assign im       = ctrl_q[3];
  // Modes 2 and 3 fall back to one-shot.
  assign periodic = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    state_d  = state_q;

    // PRESET only feeds LOAD, so a running count is untouched.
    if (preset_wr) begin
      preset_d = Din;
    end

    // A CTRL write wins over whatever the FSM would do this cycle.
    if (ctrl_wr) begin
      ctrl_d  = Din[3:0];
      flag_d  = 1'b0;
      state_d = Din[0] ? LOAD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          count_d = preset_q;
          state_d = CNT;
        end
        CNT: begin
          if (!en) begin
            state_d = IDLE;
          end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            // Covers PRESET=0 too: never wraps below zero.
            count_d = 32'd0;
            flag_d  = 1'b1;
            state_d = INT;
          end
        end
        INT: begin
          if (periodic) begin
            flag_d  = 1'b0;
            state_d = LOAD;
          end else begin
            ctrl_d[0] = 1'b0;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      state_q  <= IDLE;
      IRQ      <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
      // Built from next-state values so IRQ moves with irq_flag.
      IRQ      <= ctrl_d[3] & flag_d;
    end
  end

  always_comb begin
    Dout = 32'd0;
    if (hit) begin
      unique case (1'b1)
        (wsel == W_CTRL):   Dout = {28'd0, im, ctrl_q[2:1], en};
        (wsel == W_PRESET): Dout = preset_q;
        (wsel == W_COUNT):  Dout = count_q;
        default:            Dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: vector table plus scoreboarded cycle sequences
// for two timer_counter instances (0x7F00 and 0x7F10).
module tb_timer_counter;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_W3   = 32'h0000_7F0C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] dout0, dout1;
  logic        irq0, irq1;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(32'h0000_7F00)) u0 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(dout0), .IRQ(irq0)
  );

  timer_counter #(.BASE_ADDR(32'h0000_7F10)) u1 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(dout1), .IRQ(irq1)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        cd;
    logic [31:0] xd;
    logic        ci;
    logic        xi;
    logic        c1;
    logic [31:0] x1;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic        cd;
    logic [31:0] xd;
    logic        ci;
    logic        xi;
    logic        c1;
    logic [31:0] x1;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic we, logic [31:0] a, logic [31:0] d,
    logic cd, logic [31:0] xd, logic ci, logic xi, string tag,
    logic c1 = 1'b0, logic [31:0] x1 = 32'd0);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.d = d;
    v.cd = cd; v.xd = xd; v.ci = ci; v.xi = xi;
    v.c1 = c1; v.x1 = x1; v.tag = tag;
    return v;
  endfunction

  // One-shot COUNT seen m edges after the enabling CTRL write.
  function automatic logic [31:0] os_cnt(int n, int m, logic [31:0] c0);
    int v;
    if (m == 0) return c0;
    v = n - (m - 1);
    return (v > 0) ? 32'(v) : 32'd0;
  endfunction

  // Periodic mode: reload every n+2 edges, IRQ one cycle per period.
  function automatic logic [31:0] per_cnt(int n, int m, logic [31:0] c0);
    int p;
    if (m == 0) return c0;
    p = (m - 1) % (n + 2);
    return (p < n) ? 32'(n - p) : 32'd0;
  endfunction

  function automatic logic per_irq(int n, int m);
    return (m >= n + 1) && (((m - n - 1) % (n + 2)) == 0);
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      ncmp++; nerr++;
      $display("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (e.cd) begin
      ncmp++;
      if (dout0 !== e.xd) begin
        nerr++;
        $display("FAIL %s: Dout=%h want %h", e.tag, dout0, e.xd);
      end
    end
    if (e.ci) begin
      ncmp++;
      if (irq0 !== e.xi) begin
        nerr++;
        $display("FAIL %s: IRQ=%b want %b", e.tag, irq0, e.xi);
      end
    end
    if (e.c1) begin
      ncmp++;
      if (dout1 !== e.x1) begin
        nerr++;
        $display("FAIL %s: u1 Dout=%h want %h", e.tag, dout1, e.x1);
      end
    end
    if (e.a[31:4] == 28'h0000_7F0) begin
      ncmp++;
      if (dout1 !== 32'd0 || irq1 !== 1'b0) begin
        nerr++;
        $display("FAIL %s u1_iso: Dout=%h IRQ=%b want 0/0",
                 e.tag, dout1, irq1);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; WE = v.we; Addr = v.a; Din = v.d;
    e.a = v.a; e.cd = v.cd; e.xd = v.xd; e.ci = v.ci; e.xi = v.xi;
    e.c1 = v.c1; e.x1 = v.x1; e.tag = v.tag;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] xd,
                    input logic xi, input string tag);
    apply(mk(1'b0, 1'b0, a, 32'd0, 1'b1, xd, 1'b1, xi, tag));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic xi, input string tag);
    apply(mk(1'b0, 1'b1, a, d, 1'b0, 32'd0, 1'b1, xi, tag));
  endtask

  initial begin
    // Reset and basic register access vectors.
    tbl.push_back(mk(1, 0, A_CTRL, 0, 0, 0, 0, 0, "rst"));
    tbl.push_back(mk(1, 0, A_CTRL, 0, 0, 0, 0, 0, "rst"));
    tbl.push_back(mk(0, 0, A_CTRL, 0, 1, 0, 1, 0, "rst_ctrl"));
    tbl.push_back(mk(0, 0, A_PRE, 0, 1, 0, 1, 0, "rst_pre"));
    tbl.push_back(mk(0, 0, A_CNT, 0, 1, 0, 1, 0, "rst_cnt"));
    tbl.push_back(mk(0, 0, A_W3, 0, 1, 0, 1, 0, "rst_w3"));
    tbl.push_back(mk(0, 1, A_PRE, 5, 1, 0, 1, 0, "wr_pre5"));
    tbl.push_back(mk(0, 0, A_PRE, 0, 1, 5, 1, 0, "rd_pre5"));
    tbl.push_back(mk(0, 0, 32'h7F07, 0, 1, 5, 1, 0, "rd_pre_b3"));
    tbl.push_back(mk(0, 1, A_CTRL, 32'hFFFF_FFF6, 0, 0, 1, 0, "wr_ctrl_f6"));
    tbl.push_back(mk(0, 0, A_CTRL, 0, 1, 6, 1, 0, "ctrl_4bit"));
    tbl.push_back(mk(0, 1, 32'h7F01, 0, 0, 0, 1, 0, "wr_ctrl0"));
    tbl.push_back(mk(0, 0, A_CTRL, 0, 1, 0, 1, 0, "ctrl_clr"));
    tbl.push_back(mk(0, 0, 32'h0000_8F00, 0, 1, 0, 1, 0, "miss"));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // One-shot, PRESET=5, IM=1.
    wr(A_CTRL, 32'h9, 0, "os5_go");
    for (int m = 0; m < 7; m++)
      rd(A_CNT, os_cnt(5, m, 0), m >= 6, "os5_cnt");
    rd(A_CTRL, 32'h8, 1, "os5_autoclr");
    rd(A_CNT, 0, 1, "os5_hold");
    rd(A_CNT, 0, 1, "os5_hold2");
    wr(A_CTRL, 32'h0, 1, "os5_stop");
    rd(A_CTRL, 0, 0, "os5_irq_drop");

    // Periodic, PRESET=3.
    wr(A_PRE, 3, 0, "per_pre");
    wr(A_CTRL, 32'hB, 0, "per_go");
    for (int m = 0; m < 20; m++)
      rd(A_CNT, per_cnt(3, m, 0), per_irq(3, m), "per_cnt");
    rd(A_CTRL, 32'hB, per_irq(3, 20), "per_en_kept");
    wr(A_CTRL, 32'h0, per_irq(3, 21), "per_stop");
    rd(A_CNT, 3, 0, "per_frozen");

    // One-shot with IM=0, then re-arm with IM=1.
    wr(A_PRE, 4, 0, "im0_pre");
    wr(A_CTRL, 32'h1, 0, "im0_go");
    for (int m = 0; m < 8; m++)
      rd(A_CNT, os_cnt(4, m, 3), 0, "im0_cnt");
    rd(A_CTRL, 0, 0, "im0_autoclr");
    wr(A_CTRL, 32'h9, 0, "rearm_go");
    for (int m = 0; m < 7; m++)
      rd(A_CNT, os_cnt(4, m, 0), m >= 5, "rearm_cnt");
    wr(A_CTRL, 32'h0, 1, "rearm_stop");
    rd(A_CTRL, 0, 0, "rearm_drop");

    // PRESET write mid-count leaves the running count alone.
    wr(A_PRE, 10, 0, "mid_pre10");
    wr(A_CTRL, 32'h1, 0, "mid_go");
    for (int m = 0; m < 4; m++)
      rd(A_CNT, os_cnt(10, m, 0), 0, "mid_cnt");
    apply(mk(0, 1, A_PRE, 100, 1, 10, 1, 0, "mid_pre100"));
    for (int m = 5; m < 13; m++)
      rd(A_CNT, os_cnt(10, m, 0), 0, "mid_cnt2");
    rd(A_PRE, 100, 0, "mid_pre_rd");

    // CTRL=0 at COUNT=3 freezes the count.
    wr(A_PRE, 8, 0, "frz_pre");
    wr(A_CTRL, 32'h9, 0, "frz_go");
    for (int m = 0; m < 6; m++)
      rd(A_CNT, os_cnt(8, m, 0), 0, "frz_cnt");
    apply(mk(0, 1, A_CTRL, 0, 1, 32'h9, 1, 0, "frz_stop"));
    for (int m = 7; m < 12; m++)
      rd(A_CNT, 3, 0, "frz_hold");
    rd(A_CTRL, 0, 0, "frz_ctrl");

    // COUNT and word 3 are not writable.
    wr(A_CNT, 32'h55, 0, "wr_cnt");
    rd(A_CNT, 3, 0, "cnt_ro");
    wr(A_W3, 32'h77, 0, "wr_w3");
    rd(A_W3, 0, 0, "w3_ro");
    rd(A_CTRL, 0, 0, "w3_ctrl");
    rd(A_PRE, 8, 0, "w3_pre");

    // CTRL write in the INT cycle beats the one-shot auto-clear.
    wr(A_PRE, 2, 0, "sc_pre");
    wr(A_CTRL, 32'h9, 0, "sc_go");
    for (int m = 0; m < 3; m++)
      rd(A_CNT, os_cnt(2, m, 3), 0, "sc_cnt");
    apply(mk(0, 1, A_CTRL, 32'h9, 1, 32'h9, 1, 1, "sc_int_wr"));
    rd(A_CTRL, 32'h9, 0, "sc_en_kept");
    rd(A_CNT, 2, 0, "sc_reload");
    rd(A_CNT, 1, 0, "sc_cnt1");
    rd(A_CNT, 0, 1, "sc_irq");
    rd(A_CTRL, 32'h8, 1, "sc_autoclr");
    wr(A_CTRL, 32'h0, 1, "sc_stop");
    rd(A_CTRL, 0, 0, "sc_drop");

    // Reset mid-count.
    wr(A_PRE, 6, 0, "rm_pre");
    wr(A_CTRL, 32'h9, 0, "rm_go");
    for (int m = 0; m < 3; m++)
      rd(A_CNT, os_cnt(6, m, 0), 0, "rm_cnt");
    apply(mk(1, 0, A_CNT, 0, 0, 0, 0, 0, "rm_rst"));
    rd(A_CTRL, 0, 0, "rm_ctrl");
    rd(A_PRE, 0, 0, "rm_pre_rd");
    rd(A_CNT, 0, 0, "rm_cnt_rd");
    rd(A_CNT, 0, 0, "rm_cnt_idle");

    // Second instance decodes only its own window.
    apply(mk(0, 1, 32'h7F14, 32'h1234, 1, 0, 1, 0, "u1_wr",
             1'b1, 32'd0));
    apply(mk(0, 0, 32'h7F14, 0, 1, 0, 1, 0, "u1_pre",
             1'b1, 32'h1234));
    apply(mk(0, 0, 32'h7F10, 0, 1, 0, 1, 0, "u1_ctrl",
             1'b1, 32'd0));

    @(negedge clk);
    WE = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
